// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
package serial_pkg;

    localparam int DATA_BITS = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // odd = 0 gives even parity: the bit makes the total count of ones even.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// Bit-period timer: o_tick is high in the last cycle of each CLKS_PER_BIT-cycle bit period.
// Held at zero while i_clear is high, so a new frame always starts on a fresh period.
module serial_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    generate
        if (CLKS_PER_BIT <= 1) begin : g_const
            logic w_unused;
            assign w_unused = ^{clk, rst, i_clear};
            assign o_tick   = 1'b1;
        end else begin : g_cnt
            localparam int CNT_W = $clog2(CLKS_PER_BIT);
            logic [CNT_W-1:0] r_cnt;

            assign o_tick = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

            always_ff @(posedge clk) begin
                if (rst || i_clear || o_tick) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/serial_transmitter.sv
// Serial link transmitter: start bit, 7 data bits LSB first, parity, STOP_BITS stop bits.
// A one-word holding buffer behind a valid/ready handshake lets frames run back to back.
module serial_transmitter
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 serial_out
);

    generate
        if (CLKS_PER_BIT < 1 || STOP_BITS < 1) begin : g_bad_param
            $error("serial_transmitter: CLKS_PER_BIT and STOP_BITS must both be at least 1");
        end
    endgenerate

    // The index counts data bits in DATA and stop bits in STOP, so it must hold both ranges.
    localparam int IDX_W = (STOP_BITS > 8) ? $clog2(STOP_BITS) : 3;

    tx_state_t            r_state;
    tx_state_t            w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic                 r_parity;
    logic                 w_parity_nxt;
    logic [DATA_BITS-1:0] r_hold_data;
    logic                 r_hold_full;
    logic                 r_serial_out;
    logic                 w_load;
    logic                 w_hs;
    logic                 w_tick;

    serial_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .i_clear(r_state == ST_IDLE),
        .o_tick (w_tick)
    );

    assign w_hs       = tx_valid && !r_hold_full;
    assign tx_ready   = !r_hold_full;
    assign busy       = (r_state != ST_IDLE);
    assign serial_out = r_serial_out;

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_idx_nxt    = r_idx;
        w_parity_nxt = r_parity;
        w_load       = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_hold_full) begin
                    w_load = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                    w_idx_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                    if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                        w_state_nxt = ST_PARITY;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = ST_STOP;
                    w_idx_nxt   = '0;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_idx == IDX_W'(STOP_BITS - 1)) begin
                        done        = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_load      = r_hold_full;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Loading from either IDLE or the final stop cycle starts the next frame immediately.
        if (w_load) begin
            w_state_nxt  = ST_START;
            w_shift_nxt  = r_hold_data;
            w_parity_nxt = calc_parity(r_hold_data, PARITY_ODD);
            w_idx_nxt    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_idx    <= '0;
            r_parity <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_idx    <= w_idx_nxt;
            r_parity <= w_parity_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
        end else begin
            if (w_hs) begin
                r_hold_data <= data_in;
            end
            r_hold_full <= w_hs || (r_hold_full && !w_load);
        end
    end

    // Line follows the state one cycle later, so it is a pure flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_serial_out <= 1'b1;
        end else begin
            case (r_state)
                ST_START:  r_serial_out <= 1'b0;
                ST_DATA:   r_serial_out <= r_shift[0];
                ST_PARITY: r_serial_out <= r_parity;
                default:   r_serial_out <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: two instances (1 clk/bit, 1 stop; 4 clk/bit, 2 stops) checked every cycle
// against a frame-timing model built from accept times and the frame layout.
module tb_serial_transmitter;

    logic       clk = 1'b0;
    logic       rst_i [2];
    logic       vld   [2];
    logic [6:0] din   [2];
    logic       rdy   [2];
    logic       bsy   [2];
    logic       dne   [2];
    logic       sout  [2];

    always #5 clk = ~clk;

    serial_transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut1 (
        .clk(clk), .rst(rst_i[0]), .tx_valid(vld[0]), .data_in(din[0]),
        .tx_ready(rdy[0]), .busy(bsy[0]), .done(dne[0]), .serial_out(sout[0])
    );

    serial_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_ODD(1'b0)) dut4 (
        .clk(clk), .rst(rst_i[1]), .tx_valid(vld[1]), .data_in(din[1]),
        .tx_ready(rdy[1]), .busy(bsy[1]), .done(dne[1]), .serial_out(sout[1])
    );

    typedef struct {
        int         d;
        int         s;
        logic [6:0] w;
    } frame_t;

    frame_t frames[$];
    int     n_chk = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     free_cyc [2];
    int     s_prev   [2];
    bit     acc_flag [2];

    function automatic int cpb(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int flen(input int d);
        return (d == 0) ? 10 : 44;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_outputs(input int d);
        logic el, eb, ed, er;
        int   k;
        el = 1'b1; eb = 1'b0; ed = 1'b0;
        er = (cyc >= free_cyc[d]);
        for (int i = frames.size() - 1; i >= 0; i--)
            if (cyc > frames[i].s + flen(frames[i].d)) frames.delete(i);
        foreach (frames[i]) begin
            if (frames[i].d == d) begin
                if (cyc >= frames[i].s - 1 && cyc <= frames[i].s + flen(d) - 2) eb = 1'b1;
                if (cyc == frames[i].s + flen(d) - 2) ed = 1'b1;
                if (cyc >= frames[i].s && cyc <= frames[i].s + flen(d) - 1) begin
                    k = (cyc - frames[i].s) / cpb(d);
                    if (k == 0)      el = 1'b0;
                    else if (k <= 7) el = frames[i].w[k-1];
                    else if (k == 8) el = ^frames[i].w;
                    else             el = 1'b1;
                end
            end
        end
        check($sformatf("d%0d serial_out c%0d", d, cyc), 32'(sout[d]), 32'(el));
        check($sformatf("d%0d busy c%0d", d, cyc), 32'(bsy[d]), 32'(eb));
        check($sformatf("d%0d done c%0d", d, cyc), 32'(dne[d]), 32'(ed));
        check($sformatf("d%0d tx_ready c%0d", d, cyc), 32'(rdy[d]), 32'(er));
    endtask

    // One clock: decide the model's reaction to the held inputs, take the edge, then compare.
    task automatic step();
        bit     acc [2];
        bit     rs  [2];
        frame_t f;
        for (int d = 0; d < 2; d++) begin
            rs[d]  = rst_i[d];
            acc[d] = !rst_i[d] && vld[d] && (cyc >= free_cyc[d]);
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rs[d]) begin
                for (int i = frames.size() - 1; i >= 0; i--)
                    if (frames[i].d == d) frames.delete(i);
                free_cyc[d] = 0;
                s_prev[d]   = -1000;
            end else if (acc[d]) begin
                f.d = d;
                f.w = din[d];
                f.s = (cyc + 2 > s_prev[d] + flen(d)) ? cyc + 2 : s_prev[d] + flen(d);
                frames.push_back(f);
                s_prev[d]   = f.s;
                free_cyc[d] = f.s - 1;
                acc_flag[d] = 1'b1;
            end
        end
        @(negedge clk);
        check_outputs(0);
        check_outputs(1);
    endtask

    // Leaves tx_valid asserted so a following send can run back to back.
    task automatic send(input int d, input logic [6:0] w);
        vld[d] = 1'b1;
        din[d] = w;
        acc_flag[d] = 1'b0;
        for (int i = 0; i < 200 && !acc_flag[d]; i++) step();
        if (!acc_flag[d]) check($sformatf("d%0d accept timeout", d), 32'(acc_flag[d]), 32'd1);
    endtask

    task automatic idle(input int d, input int n);
        vld[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            din[d] = 7'($urandom);
            step();
        end
    endtask

    task automatic drain(input int d);
        idle(d, s_prev[d] + flen(d) + 2 - cyc > 0 ? s_prev[d] + flen(d) + 2 - cyc : 1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_i[d] = 1'b1; vld[d] = 1'b0; din[d] = '0;
            free_cyc[d] = 0; s_prev[d] = -1000; acc_flag[d] = 1'b0;
        end
        repeat (3) step();
        rst_i[0] = 1'b0; rst_i[1] = 1'b0;
        step();

        send(0, 7'h55); drain(0);
        send(0, 7'h01); send(0, 7'h7F); drain(0);
        for (int w = 0; w < 128; w++) send(0, 7'(w));
        drain(0);
        send(1, 7'h2A); drain(1);

        // Reset while sending data bits with a word waiting in the buffer.
        send(0, 7'h0F); send(0, 7'h70);
        vld[0] = 1'b0;
        repeat (4) step();
        rst_i[0] = 1'b1; step();
        rst_i[0] = 1'b0; idle(0, 25);

        send(1, 7'h12); send(1, 7'h4C); vld[1] = 1'b0;
        repeat (30) step();
        rst_i[1] = 1'b1; step();
        rst_i[1] = 1'b0; idle(1, 100);

        // A pulse while the buffer is occupied must not be captured.
        send(0, 7'h11); send(0, 7'h22);
        din[0] = 7'h33; step();
        vld[0] = 1'b0; drain(0);

        for (int i = 0; i < 150; i++) begin
            int d;
            d = (i % 5 == 4) ? 1 : 0;
            send(d, 7'($urandom));
            if ($urandom_range(0, 2) == 0) idle(d, $urandom_range(0, 14));
        end
        vld[0] = 1'b0; vld[1] = 1'b0;
        drain(0); drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
